mb16_booth_r8_top: RTL and testbench
====================================

// Module: mb16_booth_r8_top
// PURPOSE
//  16-bit unsigned radix-8 (modified Booth) multiplier datapath, returning the low WIDTH bits of mx*my.
//  Consumes a pre-encoded multiplier (one-hot s/d/t/q digit magnitudes plus a sign flag n per radix-8 group),
//  the multiplicand my, and its precomputed triple tmy = 3*my.
//  A combinational Booth encoder (same file, own submodule) derives s/d/t/q/n from mx.
//  Pipelined: input register stage, then partial-product sum plus product register.
// PARAMETERS
//  WIDTH      16             operand and product width
//  GROUP_CNT  (WIDTH>>2)+2   radix-8 digit count (6 for WIDTH=16); localparam
// PORTS
//  CLK      in   1          single clock, rising edge
//  RST      in   1          asynchronous, active-high reset
//  s        in   GROUP_CNT  digit i magnitude 1
//  d        in   GROUP_CNT  digit i magnitude 2
//  t        in   GROUP_CNT  digit i magnitude 3
//  q        in   GROUP_CNT  digit i magnitude 4
//  n        in   GROUP_CNT  digit i negative
//  my       in   WIDTH      multiplicand, unsigned
//  tmy      in   WIDTH+2    3*my, exact, supplied by the caller
//  s2..n2   out  GROUP_CNT  registered copies of s,d,t,q,n
//  my2      out  WIDTH      registered my
//  tmy2     out  WIDTH+2    registered tmy
//  product  out  WIDTH      (mx*my) mod 2^WIDTH
// BEHAVIOUR
//  Reset: while RST=1, all registers clear asynchronously; every output reads 0.
//  Stage 1 (edge k): s2,d2,t2,q2,n2,my2 and tmy2 load their inputs.
//  Stage 2 (edge k+1): product loads the sum of the stage-1 partial products.
//  Latency: exactly 2 rising edges, input-to-product. Throughput 1 per cycle. No handshake, no stall.
//  Encoder: extend mx to x[17:-1], where x[-1]=0 and x[17:16]=0.
//    Group i covers b3..b0 = x[3i+2], x[3i+1], x[3i], x[3i-1].
//    Digit value v = -4*b3 + 2*b2 + b1 + b0, range -4..+4.
//    |v|=1,2,3,4 sets s,d,t,q respectively; n=1 only when v<0.
//    v=0 clears all five bits, including n. At most one of s/d/t/q is set.
//  Partial product i:
//    M = my (s), my<<1 (d), tmy (t), my<<2 (q), or 0 (none).
//    PP_i = (n ? -M : M) << 3i.
//    Two's-complement negation may use invert plus a carry-in at bit 3i. Truncate to WIDTH bits.
//  product = sum of PP_0..PP_{GROUP_CNT-1} mod 2^WIDTH. Must equal the exact low half of the unsigned product.
//    No approximation; overflow beyond bit WIDTH-1 is discarded.
//  Reset asserted mid-stream: in-flight results are discarded.
//    The first product after release comes from inputs sampled at the first post-release edge, 2 edges later.
//  Inputs must be stable around the rising edge. tmy != 3*my is caller error; no checking is required.
// TESTING
//  Reset: RST=1 with arbitrary inputs -> product, s2..n2, my2, tmy2 all 0. Release, then the normal pipeline resumes.
//  Encoder mx=4: group0 q=1,n=1; group1 s=1; all other groups 0.
//    With my=0x1234 (tmy=0x369C) -> product=0x48D0 after 2 edges.
//  mx=3, my=5: group0 t=1 -> product=0x000F.
//    mx=0xFFFF, my=0xFFFF -> product=0x0001.
//  Truncation: mx=0x0100, my=0x0100 -> 0x0000.
//    mx=0x8000, my=3 -> 0x8000.
//    mx=0, my=0xABCD -> 0x0000.
//  Streaming: new random mx/my every cycle, 10000 vectors -> product at edge k+1 equals
//    (mx*my) & 0xFFFF of vectors sampled at edge k; zero mismatches.
//  Async reset pulse mid-stream between edges -> outputs go 0 immediately, not at the next edge.

Source files
------------

// File: rtl/mb16_booth_r8_top.sv
// Radix-8 modified-Booth multiplier returning the low WIDTH bits of mx*my.
// The encoder is a standalone combinational block; the top consumes pre-encoded digits.

module mb16_booth_r8_enc #(
    parameter int WIDTH = 16,
    localparam int GROUP_CNT = (WIDTH >> 2) + 2
) (
    input  logic [WIDTH-1:0]     mx,
    output logic [GROUP_CNT-1:0] s,
    output logic [GROUP_CNT-1:0] d,
    output logic [GROUP_CNT-1:0] t,
    output logic [GROUP_CNT-1:0] q,
    output logic [GROUP_CNT-1:0] n
);
    // x_s[0] is the implicit x[-1]; the top bits zero-extend mx so the last digit is never negative
    localparam int XW = 3 * GROUP_CNT + 1;

    logic [XW-1:0] x_s;
    logic [3:0]    grp_s;

    assign x_s = {{(XW - WIDTH - 1){1'b0}}, mx, 1'b0};

    // Map each overlapping 4-bit window onto a one-hot magnitude and a sign flag
    always_comb begin
        s     = '0;
        d     = '0;
        t     = '0;
        q     = '0;
        n     = '0;
        grp_s = 4'b0000;
        for (int i = 0; i < GROUP_CNT; i++) begin
            grp_s = x_s[3*i +: 4];
            case (grp_s)
                4'b0001, 4'b0010: s[i] = 1'b1;
                4'b0011, 4'b0100: d[i] = 1'b1;
                4'b0101, 4'b0110: t[i] = 1'b1;
                4'b0111:          q[i] = 1'b1;
                4'b1000:          begin q[i] = 1'b1; n[i] = 1'b1; end
                4'b1001, 4'b1010: begin t[i] = 1'b1; n[i] = 1'b1; end
                4'b1011, 4'b1100: begin d[i] = 1'b1; n[i] = 1'b1; end
                4'b1101, 4'b1110: begin s[i] = 1'b1; n[i] = 1'b1; end
                default:          begin end
            endcase
        end
    end
endmodule

module mb16_booth_r8_top #(
    parameter int WIDTH = 16,
    localparam int GROUP_CNT = (WIDTH >> 2) + 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [GROUP_CNT-1:0] s,
    input  logic [GROUP_CNT-1:0] d,
    input  logic [GROUP_CNT-1:0] t,
    input  logic [GROUP_CNT-1:0] q,
    input  logic [GROUP_CNT-1:0] n,
    input  logic [WIDTH-1:0]     my,
    input  logic [WIDTH+1:0]     tmy,
    output logic [GROUP_CNT-1:0] s2,
    output logic [GROUP_CNT-1:0] d2,
    output logic [GROUP_CNT-1:0] t2,
    output logic [GROUP_CNT-1:0] q2,
    output logic [GROUP_CNT-1:0] n2,
    output logic [WIDTH-1:0]     my2,
    output logic [WIDTH+1:0]     tmy2,
    output logic [WIDTH-1:0]     product
);
    logic [WIDTH-1:0] sum_s;

    // Negation is invert-then-shift plus a carry at bit sh, which equals -(M << sh) mod 2^WIDTH
    function automatic logic [WIDTH-1:0] pp_term(
        input logic             sel_s,
        input logic             sel_d,
        input logic             sel_t,
        input logic             sel_q,
        input logic             neg,
        input logic [WIDTH-1:0] m1,
        input logic [WIDTH-1:0] m3,
        input int               sh
    );
        logic [WIDTH-1:0] m;
        logic [WIDTH-1:0] cin;
        if (sel_s)      m = m1;
        else if (sel_d) m = {m1[WIDTH-2:0], 1'b0};
        else if (sel_t) m = m3;
        else if (sel_q) m = {m1[WIDTH-3:0], 2'b00};
        else            m = '0;
        if (neg) begin
            m   = ~m;
            cin = {{(WIDTH-1){1'b0}}, 1'b1} << sh;
        end else begin
            cin = '0;
        end
        return (m << sh) + cin;
    endfunction

    // Stage 1: capture the encoded digits and both multiplicand forms
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s2   <= '0;
            d2   <= '0;
            t2   <= '0;
            q2   <= '0;
            n2   <= '0;
            my2  <= '0;
            tmy2 <= '0;
        end else begin
            s2   <= s;
            d2   <= d;
            t2   <= t;
            q2   <= q;
            n2   <= n;
            my2  <= my;
            tmy2 <= tmy;
        end
    end

    // Accumulate the partial products of the registered digits
    always_comb begin
        sum_s = '0;
        for (int i = 0; i < GROUP_CNT; i++) begin
            sum_s = sum_s + pp_term(s2[i], d2[i], t2[i], q2[i], n2[i],
                                    my2, tmy2[WIDTH-1:0], 3 * i);
        end
    end

    // Stage 2: register the truncated product
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            product <= '0;
        end else begin
            product <= sum_s;
        end
    end
endmodule

// File: tb/tb_mb16_booth_r8_top.sv
// Scoreboarded bench: stimulus pushes expectations, a negedge monitor pops and compares.
// Reference is plain arithmetic (mx*my) plus a digit-value encoder model.

module tb_mb16_booth_r8_top;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [15:0] mx  = 16'h0000;
    logic [15:0] my  = 16'h0000;
    logic [17:0] tmy = 18'h00000;
    logic [5:0]  enc_s, enc_d, enc_t, enc_q, enc_n;
    logic [5:0]  s2, d2, t2, q2, n2;
    logic [15:0] my2, product;
    logic [17:0] tmy2;

    typedef struct packed {
        logic [29:0] enc;
        logic [15:0] my;
        logic [17:0] tmy;
    } st1_t;

    st1_t        q1[$];
    logic [15:0] q2_exp[$];
    logic        drv_valid = 1'b0;
    logic        v1 = 1'b0;
    logic        v2 = 1'b0;
    int          total = 0;
    int          bad = 0;

    always #5 CLK = ~CLK;

    mb16_booth_r8_enc u_enc (
        .mx(mx), .s(enc_s), .d(enc_d), .t(enc_t), .q(enc_q), .n(enc_n)
    );

    mb16_booth_r8_top dut (
        .CLK(CLK), .RST(RST),
        .s(enc_s), .d(enc_d), .t(enc_t), .q(enc_q), .n(enc_n),
        .my(my), .tmy(tmy),
        .s2(s2), .d2(d2), .t2(t2), .q2(q2), .n2(n2),
        .my2(my2), .tmy2(tmy2), .product(product)
    );

    // Digit i value = -4*x[3i+2] + 2*x[3i+1] + x[3i] + x[3i-1]; packed as {s,d,t,q,n}
    function automatic logic [29:0] model_enc(input logic [15:0] x);
        logic [18:0] xe;
        logic [5:0]  ms, md, mt, mq, mn;
        int          v;
        int          mag;
        xe = {2'b00, x, 1'b0};
        ms = '0; md = '0; mt = '0; mq = '0; mn = '0;
        for (int i = 0; i < 6; i++) begin
            v = (xe[3*i+3] ? -4 : 0) + (xe[3*i+2] ? 2 : 0)
              + (xe[3*i+1] ? 1 : 0) + (xe[3*i] ? 1 : 0);
            mag = (v < 0) ? -v : v;
            if (mag == 1) ms[i] = 1'b1;
            if (mag == 2) md[i] = 1'b1;
            if (mag == 3) mt[i] = 1'b1;
            if (mag == 4) mq[i] = 1'b1;
            if (v < 0)    mn[i] = 1'b1;
        end
        return {ms, md, mt, mq, mn};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [15:0] x, input logic [15:0] y, input logic [15:0] exp_p);
        st1_t e;
        mx  = x;
        my  = y;
        tmy = {2'b00, y} * 18'd3;
        #1;
        check("encoder", {enc_s, enc_d, enc_t, enc_q, enc_n}, model_enc(x));
        e.enc = model_enc(x);
        e.my  = y;
        e.tmy = {2'b00, y} * 18'd3;
        q1.push_back(e);
        q2_exp.push_back(exp_p);
        drv_valid = 1'b1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_product"}, product, 64'd0);
        check({tag, "_digits"}, {s2, d2, t2, q2, n2}, 64'd0);
        check({tag, "_my"}, {my2, tmy2}, 64'd0);
    endtask

    // Latency bookkeeping: which output stages hold a scored transaction
    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else begin
            v1 <= drv_valid;
            v2 <= v1;
        end
    end

    // Monitor
    always @(negedge CLK) begin
        st1_t        e;
        logic [15:0] p;
        if (v1) begin
            if (q1.size() == 0) begin
                check("stage1_underflow", 64'd1, 64'd0);
            end else begin
                e = q1.pop_front();
                check("stage1_digits", {s2, d2, t2, q2, n2}, e.enc);
                check("stage1_my", {my2, tmy2}, {e.my, e.tmy});
            end
        end
        if (v2) begin
            if (q2_exp.size() == 0) begin
                check("product_underflow", 64'd1, 64'd0);
            end else begin
                p = q2_exp.pop_front();
                check("product", product, p);
            end
        end
    end

    logic [15:0] dir_x [6] = '{16'h0004, 16'h0003, 16'hFFFF, 16'h0100, 16'h8000, 16'h0000};
    logic [15:0] dir_y [6] = '{16'h1234, 16'h0005, 16'hFFFF, 16'h0100, 16'h0003, 16'hABCD};
    logic [15:0] dir_p [6] = '{16'h48D0, 16'h000F, 16'h0001, 16'h0000, 16'h8000, 16'h0000};

    initial begin
        logic [15:0] rx, ry;
        // Reset with arbitrary inputs applied
        RST = 1'b1;
        mx  = 16'hBEEF;
        my  = 16'h7357;
        tmy = {2'b00, my} * 18'd3;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check_zero("reset");

        // Spot-check encoder against literal digit patterns
        mx = 16'h0004;
        #1;
        check("enc_mx4", {enc_s, enc_d, enc_t, enc_q, enc_n},
              {6'b000010, 6'b000000, 6'b000000, 6'b000001, 6'b000001});
        mx = 16'h0003;
        #1;
        check("enc_mx3", {enc_s, enc_d, enc_t, enc_q, enc_n},
              {6'b000000, 6'b000000, 6'b000001, 6'b000000, 6'b000000});

        @(posedge CLK);
        #2;
        RST = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(dir_x[i], dir_y[i], dir_p[i]);
            @(posedge CLK);
            #2;
        end

        for (int i = 0; i < 10000; i++) begin
            if (i == 5000) begin
                // Asynchronous pulse between edges: outputs must clear without a clock
                #1;
                RST = 1'b1;
                #1;
                check_zero("async_reset");
                q1.delete();
                q2_exp.delete();
                drv_valid = 1'b0;
                RST = 1'b0;
            end
            rx = 16'($urandom);
            ry = 16'($urandom);
            drive(rx, ry, 16'((32'(rx) * 32'(ry)) & 32'h0000FFFF));
            @(posedge CLK);
            #2;
        end
        drv_valid = 1'b0;

        repeat (4) @(negedge CLK);
        check("drain", 64'(q1.size() + q2_exp.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
